serial_sub: RTL and testbench

//  Bit-serial subtractor computing a_i - b_i over WIDTH clock cycles, LSB first.

---
 rtl/serial_sub.sv | 148 ++++++++++++++
 tb/tb_serial_sub.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b over WIDTH cycles, LSB first, with a start/done handshake.
// Optional SERIAL_SUB_OVF_EN adds ovf_o, the signed overflow of a - b.
module serial_sub #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] diff_o,
`ifdef SERIAL_SUB_OVF_EN
   output logic             ovf_o,
`endif
   output logic             borrow_o
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned RES_W = WIDTH - 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_e;

   state_e             state_q,  state_d;
   logic [WIDTH-1:0]   a_sr_q,   a_sr_d;
   logic [WIDTH-1:0]   b_sr_q,   b_sr_d;
   logic [RES_W-1:0]   res_q,    res_d;
   logic               br_q,     br_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic               busy_q,   busy_d;
   logic               done_q,   done_d;
   logic [WIDTH-1:0]   diff_q,   diff_d;
   logic               borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVF_EN
   logic               ovf_q,    ovf_d;
`endif

   logic a_bit, b_bit, hs1_d, hs1_b, d_bit, hs2_b, br_next;

   // One full-subtractor cell built from two half-subtractor stages.
   always_comb begin
      a_bit   = a_sr_q[0];
      b_bit   = b_sr_q[0];
      hs1_d   = a_bit ^ b_bit;
      hs1_b   = ~a_bit & b_bit;
      d_bit   = hs1_d ^ br_q;
      hs2_b   = ~hs1_d & br_q;
      br_next = hs1_b | hs2_b;
   end

   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      res_d    = res_q;
      br_d     = br_q;
      cnt_d    = cnt_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      diff_d   = diff_q;
      borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
      ovf_d    = ovf_q;
`endif

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               state_d = ST_SHIFT;
               busy_d  = 1'b1;
               a_sr_d  = a_i;
               b_sr_d  = b_i;
               br_d    = 1'b0;
               cnt_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            a_sr_d = a_sr_q >> 1;
            b_sr_d = b_sr_q >> 1;
            // Result bits enter at the top so bit 0 lands at the LSB after WIDTH-1 shifts.
            res_d  = RES_W'({d_bit, res_q} >> 1);
            br_d   = br_next;
            cnt_d  = cnt_q + CNT_W'(1);
            busy_d = 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d  = ST_DONE;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               cnt_d    = '0;
               diff_d   = {d_bit, res_q};
               borrow_d = br_next;
`ifdef SERIAL_SUB_OVF_EN
               ovf_d    = (a_bit ^ b_bit) & (a_bit ^ d_bit);
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         res_q    <= '0;
         br_q     <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         res_q    <= res_d;
         br_q     <= br_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign diff_o   = diff_q;
   assign borrow_o = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf_o    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub (WIDTH=8): handshake timing, results, hold behaviour, reset abort.
module tb_serial_sub;

   localparam int unsigned WIDTH = 8;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             start_i;
   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] diff_o;
   logic             borrow_o;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf_o;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   logic [WIDTH-1:0] exp_diff   = '0;
   logic             exp_borrow = 1'b0;
   logic             exp_ovf    = 1'b0;

   serial_sub #(.WIDTH(WIDTH)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (start_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .diff_o  (diff_o),
`ifdef SERIAL_SUB_OVF_EN
      .ovf_o   (ovf_o),
`endif
      .borrow_o(borrow_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_outs(input string tag);
      chk({tag, "_diff"},   32'(diff_o),   32'(exp_diff));
      chk({tag, "_borrow"}, 32'(borrow_o), 32'(exp_borrow));
`ifdef SERIAL_SUB_OVF_EN
      chk({tag, "_ovf"},    32'(ovf_o),    32'(exp_ovf));
`endif
   endtask

   // Starts an op, checks WIDTH busy cycles with held outputs, ends in the DONE cycle.
   task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] d_ref, input logic br_ref, input int glitch_at);
      start_i = 1'b1;
      a_i     = a;
      b_i     = b;
      step();
      a_i = ~a;
      b_i = ~b;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (i == glitch_at) begin
            start_i = 1'b1;
            a_i     = 8'h00;
            b_i     = 8'hFF;
         end else begin
            start_i = 1'b0;
         end
         chk("shift_busy", 32'(busy_o), 32'd1);
         chk("shift_done", 32'(done_o), 32'd0);
         chk_outs("shift_hold");
         step();
      end
      start_i    = 1'b0;
      exp_diff   = d_ref;
      exp_borrow = br_ref;
      exp_ovf    = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ d_ref[WIDTH-1]);
      chk("done_pulse", 32'(done_o), 32'd1);
      chk("done_busy",  32'(busy_o), 32'd0);
      chk_outs("result");
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         chk("idle_done", 32'(done_o), 32'd0);
         chk("idle_busy", 32'(busy_o), 32'd0);
         chk_outs("idle_hold");
      end
   endtask

   initial begin
      rst_i   = 1'b1;
      start_i = 1'b0;
      a_i     = '0;
      b_i     = '0;
      step();
      step();
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk_outs("rst");
      rst_i = 1'b0;
      idle(2);

      do_op(8'h35, 8'h12, 8'h23, 1'b0, -1);
      idle(2);
      do_op(8'h12, 8'h35, 8'hDD, 1'b1, -1);
      idle(1);
      do_op(8'h00, 8'h01, 8'hFF, 1'b1, -1);
      idle(1);
      do_op(8'hFF, 8'hFF, 8'h00, 1'b0, -1);
      idle(20);

      // Start during SHIFT is ignored; start in DONE is accepted back-to-back.
      do_op(8'h40, 8'h01, 8'h3F, 1'b0, 2);
      do_op(8'h90, 8'h30, 8'h60, 1'b0, -1);
      idle(2);
      do_op(8'hA5, 8'h00, 8'hA5, 1'b0, -1);
      idle(2);

      // Reset in the fourth SHIFT cycle aborts with no done pulse.
      start_i = 1'b1;
      a_i     = 8'h55;
      b_i     = 8'hAA;
      step();
      start_i = 1'b0;
      step();
      step();
      step();
      chk("pre_rst_busy", 32'(busy_o), 32'd1);
      rst_i = 1'b1;
      step();
      rst_i      = 1'b0;
      exp_diff   = '0;
      exp_borrow = 1'b0;
      exp_ovf    = 1'b0;
      chk("abort_busy", 32'(busy_o), 32'd0);
      chk("abort_done", 32'(done_o), 32'd0);
      chk_outs("abort");
      idle(WIDTH + 2);

      // Reset and start on the same edge: reset wins.
      rst_i   = 1'b1;
      start_i = 1'b1;
      a_i     = 8'h07;
      b_i     = 8'h03;
      step();
      rst_i   = 1'b0;
      start_i = 1'b0;
      chk("rst_start_busy", 32'(busy_o), 32'd0);
      idle(2);

      do_op(8'h77, 8'h22, 8'h55, 1'b0, -1);
      idle(2);
      do_op(8'h80, 8'h01, 8'h7F, 1'b0, -1);
`ifdef SERIAL_SUB_OVF_EN
      chk("ovf_set", 32'(ovf_o), 32'd1);
`endif
      idle(2);
      do_op(8'h10, 8'h01, 8'h0F, 1'b0, -1);
`ifdef SERIAL_SUB_OVF_EN
      chk("ovf_clear", 32'(ovf_o), 32'd0);
`endif
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
